// File: rtl/mux4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter that shares one 4:1 select path (mux4x1) among four
//   requesters. A winner keeps its grant for as long as it holds req high.
//   The mux address comes from the registered owner index.
//
//   Optional feature: define ARB_TIMEOUT_EN to limit how long one owner can
//   hold the grant. After MAX_HOLD consecutive grant cycles the owner is
//   preempted, but only if another requester is waiting.
//
// Parameters
//   MAX_HOLD  max consecutive grant cycles per owner (ARB_TIMEOUT_EN only)
//   CNT_W     hold-counter width, 2**CNT_W > MAX_HOLD
//
// Ports
//   clk      in   1  system clock, rising edge
//   reset_n  in   1  asynchronous active-low reset
//   req      in   4  level request per requester
//   data_in  in   4  data bit per requester (mux inputs)
//   grant    out  4  one-hot grant, registered, 0 when idle
//   sel      out  2  registered owner index, mux address
//   busy     out  1  registered, 1 while grant != 0
//   out      out  1  busy ? data_in[sel] : 0
// -----------------------------------------------------------------------------

module mux4x1 (
  input  logic [3:0] muxIns,
  input  logic [1:0] addr,
  output logic       muxOut
);
  assign muxOut = muxIns[addr];
endmodule

module mux4_rr_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] req,
  input  logic [3:0] data_in,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       busy,
  output logic       out
);

  // state | meaning
  // IDLE  | no owner, grant = 0, sel keeps the last owner index
  // BUSY  | one owner holds the grant while its req stays high
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  if (MAX_HOLD < 1 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_params
    $error("mux4_rr_arbiter: need MAX_HOLD >= 1 and 2**CNT_W > MAX_HOLD");
  end

  state_t     r_state, w_nxt_state;
  logic [3:0] r_grant, w_nxt_grant;
  logic [1:0] r_sel,   w_nxt_sel;
  logic       r_busy,  w_nxt_busy;
  logic [1:0] r_ptr,   w_nxt_ptr;

  logic [3:0] w_arb_req;
  logic       w_arb_valid;
  logic [1:0] w_arb_idx;
  logic [1:0] w_scan_idx;
  logic       w_mux_out;

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(MAX_HOLD);
  logic [CNT_W-1:0] r_hold_cnt, w_nxt_hold_cnt;
`endif

  // The current owner is never a candidate. Arbitration only matters when
  // the owner releases (its req is already low) or is preempted. In IDLE,
  // r_grant is zero.
  assign w_arb_req = req & ~r_grant;

  // The scan runs from the far end of the search order toward ptr.
  // The last hit is therefore the first set bit at or after ptr.
  always_comb begin
    w_arb_valid = 1'b0;
    w_arb_idx   = 2'd0;
    w_scan_idx  = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      w_scan_idx = r_ptr + 2'(k);
      if (w_arb_req[w_scan_idx]) begin
        w_arb_valid = 1'b1;
        w_arb_idx   = w_scan_idx;
      end
    end
  end

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_grant    = r_grant;
    w_nxt_sel      = r_sel;
    w_nxt_busy     = r_busy;
    w_nxt_ptr      = r_ptr;
`ifdef ARB_TIMEOUT_EN
    w_nxt_hold_cnt = r_hold_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_arb_valid) begin
          w_nxt_state    = S_BUSY;
          w_nxt_grant    = 4'b0001 << w_arb_idx;
          w_nxt_sel      = w_arb_idx;
          w_nxt_busy     = 1'b1;
          w_nxt_ptr      = w_arb_idx + 2'd1;
`ifdef ARB_TIMEOUT_EN
          w_nxt_hold_cnt = '0;
`endif
        end
      end
      S_BUSY: begin
        if (!req[r_sel]) begin
          if (w_arb_valid) begin
            // Hand off to the next winner with no idle cycle in between.
            w_nxt_grant    = 4'b0001 << w_arb_idx;
            w_nxt_sel      = w_arb_idx;
            w_nxt_ptr      = w_arb_idx + 2'd1;
`ifdef ARB_TIMEOUT_EN
            w_nxt_hold_cnt = '0;
`endif
          end else begin
            w_nxt_state = S_IDLE;
            w_nxt_grant = 4'b0000;
            w_nxt_busy  = 1'b0;
          end
        end
`ifdef ARB_TIMEOUT_EN
        // The counter saturates. A late challenger therefore still
        // preempts on the first edge at which it is seen.
        else if (r_hold_cnt >= HOLD_LAST && w_arb_valid) begin
          w_nxt_grant    = 4'b0001 << w_arb_idx;
          w_nxt_sel      = w_arb_idx;
          w_nxt_ptr      = w_arb_idx + 2'd1;
          w_nxt_hold_cnt = '0;
        end else if (r_hold_cnt < HOLD_SAT) begin
          w_nxt_hold_cnt = r_hold_cnt + 1'b1;
        end
`endif
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_grant = 4'b0000;
        w_nxt_busy  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_grant    <= 4'b0000;
      r_sel      <= 2'd0;
      r_busy     <= 1'b0;
      r_ptr      <= 2'd0;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt <= '0;
`endif
    end else begin
      r_state    <= w_nxt_state;
      r_grant    <= w_nxt_grant;
      r_sel      <= w_nxt_sel;
      r_busy     <= w_nxt_busy;
      r_ptr      <= w_nxt_ptr;
`ifdef ARB_TIMEOUT_EN
      r_hold_cnt <= w_nxt_hold_cnt;
`endif
    end
  end

  mux4x1 u_mux (
    .muxIns (data_in),
    .addr   (r_sel),
    .muxOut (w_mux_out)
  );

  assign grant = r_grant;
  assign sel   = r_sel;
  assign busy  = r_busy;
  assign out   = r_busy & w_mux_out;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
module tb_mux4_rr_arbiter;

  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] req;
  logic [3:0] data_in;
  logic [3:0] grant;
  logic [1:0] sel;
  logic       busy;
  logic       out;

  int checks = 0;
  int errors = 0;

  mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .data_in (data_in),
    .grant   (grant),
    .sel     (sel),
    .busy    (busy),
    .out     (out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic [1:0] s;
    logic       b;
    logic       o;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: owner index (-1 = none), round-robin start, last sel, hold count
  int m_owner = -1;
  int m_ptr   = 0;
  int m_sel   = 0;
  int m_hold  = 0;

  function automatic int rr_pick(int start, logic [3:0] r, int excl);
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (start + k) % 4;
      if (r[i] && i != excl) return i;
    end
    return -1;
  endfunction

  task automatic take(int w);
    m_owner = w;
    m_sel   = w;
    m_ptr   = (w + 1) % 4;
    m_hold  = 0;
  endtask

  task automatic model_step(logic [3:0] r);
    int w;
    if (m_owner < 0) begin
      w = rr_pick(m_ptr, r, -1);
      if (w >= 0) take(w);
    end else if (!r[m_owner]) begin
      w = rr_pick(m_ptr, r, -1);
      if (w >= 0) take(w);
      else m_owner = -1;
    end else begin
`ifdef ARB_TIMEOUT_EN
      w = rr_pick(m_ptr, r, m_owner);
      if (m_hold >= MAX_HOLD - 1 && w >= 0) take(w);
      else if (m_hold < MAX_HOLD) m_hold++;
`endif
    end
  endtask

  task automatic drive(logic [3:0] r, logic [3:0] d);
    exp_t e;
    @(negedge clk);
    req     = r;
    data_in = d;
    model_step(r);
    e.g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    e.s = 2'(m_sel);
    e.b = (m_owner >= 0);
    e.o = (m_owner >= 0) ? d[m_owner] : 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic check(string name, logic [7:0] act, logic [7:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: every expectation pushed before an edge is checked just after it
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check("grant", {4'b0, grant}, {4'b0, e.g});
        check("sel",   {6'b0, sel},   {6'b0, e.s});
        check("busy",  {7'b0, busy},  {7'b0, e.b});
        check("out",   {7'b0, out},   {7'b0, e.o});
      end
    end
  end

  initial begin
    logic [3:0] r_cur;
    logic [3:0] dir_req [12];
    dir_req = '{4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b1111, 4'b1111,
                4'b1110, 4'b1111, 4'b1101, 4'b1010, 4'b1000, 4'b0000};

    reset_n = 1'b0;
    req     = 4'hf;
    data_in = 4'hf;
    #12;
    check("reset_grant", {4'b0, grant}, 8'h00);
    check("reset_busy",  {7'b0, busy},  8'h00);
    check("reset_sel",   {6'b0, sel},   8'h00);
    check("reset_out",   {7'b0, out},   8'h00);
    req = 4'h0;
    @(negedge clk);
    reset_n = 1'b1;

    foreach (dir_req[i]) drive(dir_req[i], 4'($urandom));

    r_cur = 4'b0000;
    for (int n = 0; n < 600; n++) begin
      logic [3:0] flip;
      for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 4) == 0);
      r_cur = r_cur ^ flip;
      drive(r_cur, 4'($urandom));
    end

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) check("drain", 8'(exp_q.size()), 8'h00);

    // Directed: owner 2, mux data path, then asynchronous reset mid-cycle
    @(negedge clk); req = 4'b0000;
    @(negedge clk); req = 4'b0000;
    @(negedge clk); req = 4'b0100; data_in = 4'b0100;
    @(posedge clk); #1;
    check("own2_grant", {4'b0, grant}, 8'h04);
    check("own2_sel",   {6'b0, sel},   8'h02);
    check("own2_out1",  {7'b0, out},   8'h01);
    data_in = 4'b1011;
    #1;
    check("own2_out0",  {7'b0, out},   8'h00);
    reset_n = 1'b0;
    #1;
    check("async_grant", {4'b0, grant}, 8'h00);
    check("async_busy",  {7'b0, busy},  8'h00);
    check("async_out",   {7'b0, out},   8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    req = 4'b0000;
    @(posedge clk); #1;
    check("post_rst_idle", {4'b0, grant}, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
